// File: rtl/sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_arbiter
// Brief    : N-port SRAM-like request arbiter bridged onto an AXI3 master.
//            Round-robin grant, one outstanding transaction, INCR read
//            bursts up to 256 beats, single-beat strobed writes.
// Revision : 1.0  initial release
// ============================================================================
module sram_axi_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // SRAM-like request ports
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [2*NUM_MASTERS-1:0]      m_size,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
    input  logic [8*NUM_MASTERS-1:0]      m_len,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_addr_ok,
    output logic [NUM_MASTERS-1:0]        m_data_ok,
    output logic                          m_last,
    // AXI read address
    output logic [3:0]                    arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic [1:0]                    arlock,
    output logic [3:0]                    arcache,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,
    // AXI read data
    input  logic [3:0]                    rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    // AXI write address
    output logic [3:0]                    awid,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic [1:0]                    awlock,
    output logic [3:0]                    awcache,
    output logic [2:0]                    awprot,
    output logic                          awvalid,
    input  logic                          awready,
    // AXI write data
    output logic [3:0]                    wid,
    output logic [DATA_W-1:0]             wdata,
    output logic [3:0]                    wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    // AXI write response
    input  logic [3:0]                    bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready
);

    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [NUM_MASTERS-1:0] c_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_last_grant;   // also the owner of the active transaction
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [7:0]         r_len;
    logic [1:0]         r_size;
    logic               r_aw_done;
    logic               r_w_done;

    logic [IDW-1:0]     w_cand;
    logic [IDW-1:0]     w_winner;
    logic               w_found;
    logic               w_grant;
    logic               w_ok_pulse;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [7:0]         w_sel_len;
    logic [1:0]         w_sel_size;
    logic               w_sel_wr;
    logic               w_unused;

    // Response ID/status are irrelevant with a single outstanding transaction.
    assign w_unused = ^{rid, rresp, bid, bresp};

    // Round-robin search: first requester after the last grant, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = r_last_grant;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cand = (w_cand == IDW'(NUM_MASTERS - 1)) ? '0 : w_cand + 1'b1;
            if (!w_found && m_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Multiplex the winning port's request fields.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_len   = '0;
        w_sel_size  = '0;
        w_sel_wr    = 1'b0;
        for (int p = 0; p < NUM_MASTERS; p++) begin
            if (w_winner == IDW'(p)) begin
                w_sel_addr  = m_addr[p*ADDR_W +: ADDR_W];
                w_sel_wdata = m_wdata[p*DATA_W +: DATA_W];
                w_sel_len   = m_len[p*8 +: 8];
                w_sel_size  = m_size[p*2 +: 2];
                w_sel_wr    = m_wr[p];
            end
        end
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_ok_pulse = 1'b0;
        w_aw_hs    = 1'b0;
        w_w_hs     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Reset gating keeps m_addr_ok quiet while aresetn is low.
                if (w_found && aresetn) begin
                    w_grant = 1'b1;
                    w_next  = w_sel_wr ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) w_next = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_ok_pulse = 1'b1;
                    if (rlast) w_next = S_IDLE;
                end
            end
            S_AW_W: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                w_aw_hs = r_aw_done | awready;
                w_w_hs  = r_w_done | wready;
                if (w_aw_hs && w_w_hs) w_next = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_ok_pulse = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, grant pointer, latched request and write handshake flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_last_grant <= IDW'(NUM_MASTERS - 1);
            r_addr       <= '0;
            r_wdata      <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_last_grant <= w_winner;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_len        <= w_sel_len;
                r_size       <= (w_sel_size == 2'd3) ? 2'd2 : w_sel_size;
                r_aw_done    <= 1'b0;
                r_w_done     <= 1'b0;
            end else if (r_state == S_AW_W) begin
                r_aw_done <= w_aw_hs;
                r_w_done  <= w_w_hs;
            end
        end
    end

    // Byte-lane strobes from size and low address bits.
    always_comb begin
        case (r_size)
            2'd0:    wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    wstrb = 4'b0011 << r_addr[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    assign m_addr_ok = w_grant ? (c_ONE << w_winner) : '0;
    assign m_data_ok = w_ok_pulse ? (c_ONE << r_last_grant) : '0;
    assign m_rdata   = (r_state == S_R && rvalid) ? rdata : '0;
    assign m_last    = (r_state == S_R) && rvalid && rlast;

    assign arid    = 4'(r_last_grant);
    assign araddr  = r_addr;
    assign arlen   = r_len;
    assign arsize  = {1'b0, r_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awid    = 4'(r_last_grant);
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, r_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid     = 4'(r_last_grant);
    assign wdata   = r_wdata;
    assign wlast   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_axi_arbiter
// Brief    : Directed and randomized checks of sram_axi_arbiter against a
//            transaction-level reference (round-robin pointer, lane table).
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_axi_arbiter;

    localparam int N = 3;
    localparam logic [N-1:0] c_ZERO = '0;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    m_req, m_wr;
    logic [2*N-1:0]  m_size;
    logic [32*N-1:0] m_addr, m_wdata;
    logic [8*N-1:0]  m_len;
    logic [31:0]     m_rdata;
    logic [N-1:0]    m_addr_ok, m_data_ok;
    logic            m_last;
    logic [3:0]      arid, awid, wid, rid, bid;
    logic [31:0]     araddr, awaddr, wdata, rdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize, arprot, awprot;
    logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    // Per-port request fields, packed onto the DUT buses below.
    logic [31:0] addr_a  [N];
    logic [31:0] wdata_a [N];
    logic [7:0]  len_a   [N];
    logic [1:0]  size_a  [N];
    logic        wr_a    [N];

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_last = N - 1;
    logic [31:0] rbase;

    always #5 aclk = ~aclk;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            m_wr[p]             = wr_a[p];
            m_size[2*p +: 2]    = size_a[p];
            m_addr[32*p +: 32]  = addr_a[p];
            m_wdata[32*p +: 32] = wdata_a[p];
            m_len[8*p +: 8]     = len_a[p];
        end
    end

    sram_axi_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_len(m_len), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_last(m_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic rand_fields();
        for (int p = 0; p < N; p++) begin
            wr_a[p]    = 1'($urandom_range(0, 1));
            size_a[p]  = 2'($urandom_range(0, 3));
            addr_a[p]  = $urandom;
            wdata_a[p] = $urandom;
            len_a[p]   = 8'($urandom_range(0, 5));
        end
    endtask

    // One full transaction, entered and left in an IDLE cycle (#1 after an edge).
    task automatic txn(input logic [N-1:0] reqs, input bit hold, input bit scramble,
                       input int ar_dly, input int r_gap, input int aw_dly,
                       input int w_dly, input int b_dly);
        int          win, p, nb, off, last_c;
        logic [31:0] ea, ed;
        logic [7:0]  el;
        logic [1:0]  es;
        logic        ew;
        logic [2:0]  esz;
        logic [3:0]  estrb;
        m_req = reqs;
        #3;
        win = -1;
        for (int i = 1; i <= N; i++) begin
            p = (model_last + i) % N;
            if (win < 0 && reqs[p]) win = p;
        end
        chk("grant", m_addr_ok, onehot(win));
        model_last = win;
        ea = addr_a[win]; ed = wdata_a[win]; el = len_a[win]; es = size_a[win]; ew = wr_a[win];
        esz = (es == 2'd3) ? 3'd2 : {1'b0, es};
        cyc();
        if (!hold) m_req[win] = 1'b0;
        if (scramble) rand_fields();
        if (!ew) begin
            for (int c = 0; c <= ar_dly; c++) begin
                if (scramble) m_req = N'($urandom);
                arready = (c == ar_dly);
                #3;
                chk("ar_valid", {arvalid, awvalid, m_addr_ok}, {1'b1, 1'b0, c_ZERO});
                chk("ar_fields", {arid, araddr, arlen, arsize, arburst},
                    {4'(win), ea, el, esz, 2'b01});
                cyc();
            end
            arready = 1'b0;
            for (int b = 0; b <= int'(el); b++) begin
                for (int g = 0; g < r_gap; g++) begin
                    rvalid = 1'b0;
                    #3;
                    chk("r_gap", {rready, m_data_ok, m_last}, {1'b1, c_ZERO, 1'b0});
                    cyc();
                end
                rvalid = 1'b1;
                rdata  = rbase + 32'(b);
                rlast  = (b == int'(el));
                #3;
                chk("r_beat", {m_addr_ok, m_data_ok, m_last, m_rdata},
                    {c_ZERO, onehot(win), b == int'(el), rbase + 32'(b)});
                cyc();
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
        end else begin
            nb  = (es == 2'd0) ? 1 : (es == 2'd1) ? 2 : 4;
            off = (nb == 4) ? 0 : int'(ea[1:0]);
            estrb = '0;
            for (int k = 0; k < 4; k++)
                if (k >= off && k < off + nb) estrb[k] = 1'b1;
            last_c = (aw_dly > w_dly) ? aw_dly : w_dly;
            for (int c = 0; c <= last_c; c++) begin
                if (scramble) m_req = N'($urandom);
                awready = (c == aw_dly);
                wready  = (c == w_dly);
                #3;
                chk("aw_w_valid", {arvalid, awvalid, wvalid, bready, m_addr_ok},
                    {1'b0, c <= aw_dly, c <= w_dly, 1'b0, c_ZERO});
                chk("aw_fields", {awid, wid, awaddr, awlen, awsize, wstrb, wdata, wlast},
                    {4'(win), 4'(win), ea, 8'd0, esz, estrb, ed, 1'b1});
                cyc();
            end
            awready = 1'b0;
            wready  = 1'b0;
            for (int c = 0; c <= b_dly; c++) begin
                bvalid = (c == b_dly);
                #3;
                chk("b_resp", {bready, awvalid, wvalid, m_data_ok},
                    {1'b1, 1'b0, 1'b0, (c == b_dly) ? onehot(win) : c_ZERO});
                cyc();
            end
            bvalid = 1'b0;
        end
    endtask

    initial begin
        aresetn = 1'b0;
        m_req = '1;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rid = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
        for (int p = 0; p < N; p++) begin
            wr_a[p] = 0; size_a[p] = 2; addr_a[p] = '0; wdata_a[p] = '0; len_a[p] = '0;
        end
        repeat (3) @(posedge aclk);
        #1;
        // Reset: everything quiet even with requests pending.
        chk("reset_outputs", {arvalid, awvalid, wvalid, rready, bready, m_addr_ok,
                              m_data_ok, m_last, m_rdata, araddr, awaddr, wdata},
            '0);
        aresetn = 1'b1;

        // Port 0 single read, fastest response.
        addr_a[0] = 32'h1FC0_0000; len_a[0] = 0; wr_a[0] = 0; size_a[0] = 2;
        rbase = 32'hDEAD_BEEF;
        txn(3'b001, 0, 0, 0, 0, 0, 0, 0);

        // Port 1 len-7 burst with rvalid stalled every other cycle.
        addr_a[1] = 32'h0000_1000; len_a[1] = 7; wr_a[1] = 0;
        rbase = 32'h1111_0000;
        txn(3'b010, 0, 0, 1, 1, 0, 0, 0);

        // Port 2 half write, awready late, wready immediate.
        addr_a[2] = 32'h4000_0002; wdata_a[2] = 32'hABCD_0000; size_a[2] = 1; wr_a[2] = 1;
        txn(3'b100, 0, 0, 0, 0, 3, 0, 0);

        // Continuous requests on all ports: grants must rotate.
        len_a[0] = 0; len_a[1] = 0; wr_a[1] = 1; size_a[1] = 2; wr_a[2] = 0; len_a[2] = 1;
        rbase = 32'h2222_0000;
        for (int t = 0; t < 6; t++) txn(3'b111, 1, 0, 0, 0, 0, 0, 0);

        // Byte writes at each offset, then word and size-3 writes.
        wr_a[2] = 1; wdata_a[2] = 32'h5566_7788;
        for (int off = 0; off < 4; off++) begin
            size_a[2] = 0;
            addr_a[2] = 32'h2000_0000 + 32'(off);
            txn(3'b100, 0, 0, 0, 0, 0, 1, 1);
        end
        size_a[2] = 2; addr_a[2] = 32'h2000_0001;
        txn(3'b100, 0, 0, 0, 0, 1, 0, 0);
        size_a[2] = 3; addr_a[2] = 32'h2000_0003;
        txn(3'b100, 0, 0, 0, 0, 0, 0, 2);

        // Randomized traffic with request/field churn while busy.
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            rbase = $urandom;
            txn(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)), 1,
                $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset during beat 3 of a len-7 burst on port 2.
        wr_a[2] = 0; len_a[2] = 7; addr_a[2] = 32'h3000_0000; size_a[2] = 2;
        m_req = 3'b100;
        #3;
        chk("rst_burst_grant", m_addr_ok, 3'b100);
        cyc();
        m_req = '0; arready = 1;
        #3;
        chk("rst_burst_ar", {arvalid, arlen}, {1'b1, 8'd7});
        cyc();
        arready = 0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1; rdata = 32'hCAFE_0000 + 32'(b);
            #3;
            chk("rst_burst_beat", {m_data_ok, m_rdata}, {3'b100, 32'hCAFE_0000 + 32'(b)});
            cyc();
        end
        rdata = 32'hCAFE_0003; aresetn = 1'b0;
        #3;
        chk("rst_mid_outputs", {arvalid, awvalid, wvalid, rready, bready, m_addr_ok,
                                m_data_ok, m_last, m_rdata}, '0);
        cyc();
        cyc();
        aresetn = 1'b1;
        model_last = N - 1;
        #3;
        chk("post_rst_no_data", {rready, m_data_ok, m_last, m_rdata}, '0);
        cyc();
        rvalid = 0;
        rbase = 32'h7777_0000; wr_a[0] = 0; len_a[0] = 1; addr_a[0] = 32'h0000_0040;
        txn(3'b111, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
